muldiv_unit: RTL

Parametrised multi-cycle multiply/divide/modulo unit, the iterative arithmetic engine beside the single-cycle ALU datapath. It accepts one operation per start pulse and computes it bit-serially over WIDTH cycles using shift-add multiplication and restoring division. It reports completion with a one-cycle done pulse and holds its results until the next start. The processor control stalls on busy and consumes result_lo/result_hi and the flags on done.

---
 rtl/muldiv_pkg.sv | 14 +
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings and controller states for muldiv_unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: bit-serial multiply / restoring divide / modulo engine.
// One operation per accepted start, WIDTH step cycles, one-cycle done pulse.
// Optional build macro MULDIV_SIGNED_EN enables two's-complement operation
// (magnitude conversion, sign fixup, MIN / -1 overflow flag).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             dz,
  output logic             ov,
  output logic             Z,
  output logic             N
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               div_q;      // DIV or MOD in flight
  logic               mod_q;      // modulo op in flight (swaps result halves)
  logic [WIDTH-1:0]   opnd_q;     // multiplicand (MUL) or divisor (DIV/MOD) magnitude
  logic [2*WIDTH:0]   acc;        // {carry/remainder, multiplier/quotient}
  logic [2*WIDTH:0]   acc_nxt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;

  logic               sgn_eff;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               start_div, start_mod, start_dz;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  logic [WIDTH-1:0]   dz_lo, dz_hi;

`ifdef MULDIV_SIGNED_EN
  logic               sa_q, sb_q;
  logic               ov_pend, ov_q;
  assign sgn_eff = sgn;
  assign ov      = ov_q;
`else
  assign sgn_eff = sgn & 1'b0;
  assign ov      = 1'b0;
`endif

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Operand decode at the start boundary: signs, magnitudes, divide-by-zero.
  assign a_neg     = sgn_eff & a[WIDTH-1];
  assign b_neg     = sgn_eff & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign start_div = (op == OP_DIV) || (op == OP_MOD);
  assign start_mod = (op == OP_MOD);
  assign start_dz  = start_div && (b == '0);
  assign dz_lo     = start_mod ? a : '1;
  assign dz_hi     = start_mod ? '1 : a;

  // One arithmetic step: shift-add for MUL, shift/trial-subtract for DIV.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    acc_nxt = acc;
    sum     = '0;
    rem_sh  = '0;
    if (!div_q) begin
      sum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd_q} : '0);
      acc_nxt = {sum, acc[WIDTH-1:0]} >> 1;
    end else begin
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      if (rem_sh >= {1'b0, opnd_q})
        acc_nxt = {rem_sh - {1'b0, opnd_q}, acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {rem_sh, acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup on the final step's raw result, then map onto result_lo/hi.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    prod_fix = (sa_q ^ sb_q) ? -acc_nxt[2*WIDTH-1:0] : acc_nxt[2*WIDTH-1:0];
    quo_fix  = (sa_q ^ sb_q) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rem_fix  = sa_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
`else
    prod_fix = acc_nxt[2*WIDTH-1:0];
    quo_fix  = acc_nxt[WIDTH-1:0];
    rem_fix  = acc_nxt[2*WIDTH-1:WIDTH];
`endif
    if (!div_q) begin
      fin_lo = prod_fix[WIDTH-1:0];
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    end else if (mod_q) begin
      fin_lo = rem_fix;
      fin_hi = quo_fix;
    end else begin
      fin_lo = quo_fix;
      fin_hi = rem_fix;
    end
  end

  // Controller and datapath registers: accept, step WIDTH times, publish.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_q     <= 1'b0;
      mod_q     <= 1'b0;
      opnd_q    <= '0;
      acc       <= '0;
      result_lo <= '0;
      result_hi <= '0;
      dz        <= 1'b0;
      Z         <= 1'b0;
      N         <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      ov_pend   <= 1'b0;
      ov_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state     <= S_DONE;
            result_lo <= fin_lo;
            result_hi <= fin_hi;
            Z         <= (fin_lo == '0);
            N         <= fin_lo[WIDTH-1];
`ifdef MULDIV_SIGNED_EN
            ov_q      <= ov_pend;
`endif
          end
        end
        default: begin
          if (start) begin
            div_q  <= start_div;
            mod_q  <= start_mod;
            cnt    <= '0;
            opnd_q <= start_div ? b_mag : a_mag;
            acc    <= {{(WIDTH+1){1'b0}}, (start_div ? a_mag : b_mag)};
            dz     <= start_dz;
`ifdef MULDIV_SIGNED_EN
            sa_q    <= a_neg;
            sb_q    <= b_neg;
            ov_pend <= sgn_eff && start_div && (a == MIN_VAL) && (b == '1);
            ov_q    <= 1'b0;
`endif
            if (start_dz) begin
              state     <= S_DONE;
              result_lo <= dz_lo;
              result_hi <= dz_hi;
              Z         <= (dz_lo == '0);
              N         <= dz_lo[WIDTH-1];
            end else begin
              state <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
